// File: rtl/score_pkg.sv
// Shared score interface constants and game state encoding, imported by the
// score keeper and by the seven-segment display path.
package score_pkg;

    localparam int SCORE_W     = 14;
    localparam int SCORE_MAX   = 9999;
    localparam int START_LIVES = 3;
    localparam int MAX_COMBO   = 3;

    localparam int PTS_W   = 3;
    localparam int LIVES_W = 2;
    localparam int COMBO_W = 2;
    // Multiplier is combo + 1, so it needs one more bit than the combo counter.
    localparam int MULT_W  = COMBO_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_COMMIT    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

endpackage

// File: rtl/score_sat_add.sv
// Combinational score update: score + pts * mult, clamped to SCORE_MAX.
module score_sat_add
    import score_pkg::*;
(
    input  logic [SCORE_W-1:0] score,
    input  logic [PTS_W-1:0]   pts,
    input  logic [MULT_W-1:0]  mult,
    output logic [SCORE_W-1:0] sum
);

    localparam int WIDE_W = SCORE_W + 1;
    localparam int PROD_W = PTS_W + MULT_W;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [WIDE_W-1:0] value);
        if (value > WIDE_W'(SCORE_MAX)) begin
            return SCORE_W'(SCORE_MAX);
        end
        return value[SCORE_W-1:0];
    endfunction

    logic [PROD_W-1:0] prod;
    logic [WIDE_W-1:0] wide_sum;

    // One extra bit of headroom means the sum can never wrap before clamping.
    assign prod     = PROD_W'(pts) * PROD_W'(mult);
    assign wide_sum = WIDE_W'(score) + WIDE_W'(prod);
    assign sum      = sat_score(wide_sum);

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: FSM, lives, brick combo and saturating score, with the
// high score committed once at the end of each game.
module score_keeper
    import score_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 brick_hit,
    input  logic [PTS_W-1:0]     brick_pts,
    input  logic                 paddle_hit,
    input  logic                 ball_lost,
    output logic [SCORE_W-1:0]   current_score,
    output logic [SCORE_W-1:0]   high_score,
    output logic [LIVES_W-1:0]   lives,
    output logic                 playing,
    output logic                 game_over,
    output logic                 new_high
);

    state_t               state;
    state_t               state_next;
    logic                 playing_next;
    logic                 game_over_next;
    logic [COMBO_W-1:0]   combo;
    logic [MULT_W-1:0]    mult;
    logic [SCORE_W-1:0]   score_sum;
    logic                 last_life;

    assign mult      = MULT_W'(combo) + MULT_W'(1);
    assign last_life = (lives == LIVES_W'(1));

    score_sat_add u_sat_add (
        .score (current_score),
        .pts   (brick_pts),
        .mult  (mult),
        .sum   (score_sum)
    );

    // State register; the decoded status flags are registered with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            playing   <= playing_next;
            game_over <= game_over_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    state_next = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (ball_lost && last_life) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: state_next = ST_GAME_OVER;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        playing_next   = (state_next == ST_PLAYING);
        game_over_next = (state_next == ST_GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_score <= '0;
            high_score    <= '0;
            lives         <= '0;
            combo         <= '0;
            new_high      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        current_score <= '0;
                        lives         <= LIVES_W'(START_LIVES);
                        combo         <= '0;
                        new_high      <= 1'b0;
                    end
                end
                ST_PLAYING: begin
                    // Points use the multiplier held before any clear this cycle.
                    if (brick_hit) begin
                        current_score <= score_sum;
                    end
                    if (paddle_hit || ball_lost) begin
                        combo <= '0;
                    end else if (brick_hit && (combo != COMBO_W'(MAX_COMBO))) begin
                        combo <= combo + COMBO_W'(1);
                    end
                    if (ball_lost && (lives != '0)) begin
                        lives <= lives - LIVES_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (current_score > high_score) begin
                        high_score <= current_score;
                        new_high   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a table of one-cycle event vectors with
// hand-computed outputs, plus sequences for saturation and async reset.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        brick_hit = 1'b0;
    logic [2:0]  brick_pts = 3'd0;
    logic        paddle_hit = 1'b0;
    logic        ball_lost = 1'b0;
    logic [13:0] current_score;
    logic [13:0] high_score;
    logic [1:0]  lives;
    logic        playing;
    logic        game_over;
    logic        new_high;

    int checks = 0;
    int errors = 0;

    score_keeper dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .brick_hit     (brick_hit),
        .brick_pts     (brick_pts),
        .paddle_hit    (paddle_hit),
        .ball_lost     (ball_lost),
        .current_score (current_score),
        .high_score    (high_score),
        .lives         (lives),
        .playing       (playing),
        .game_over     (game_over),
        .new_high      (new_high)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       bh;
        logic [2:0] pts;
        logic       ph;
        logic       bl;
        int         score;
        int         high;
        int         lv;
        int         pl;
        int         go;
        int         nh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic bh, input int pts,
                                input logic ph, input logic bl, input int score,
                                input int high, input int lv, input int pl,
                                input int go, input int nh);
        vec_t v;
        v.st = st; v.bh = bh; v.pts = 3'(pts); v.ph = ph; v.bl = bl;
        v.score = score; v.high = high; v.lv = lv; v.pl = pl; v.go = go; v.nh = nh;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int score, input int high,
                           input int lv, input int pl, input int go, input int nh);
        chk({tag, " current_score"}, int'(current_score), score);
        chk({tag, " high_score"}, int'(high_score), high);
        chk({tag, " lives"}, int'(lives), lv);
        chk({tag, " playing"}, int'(playing), pl);
        chk({tag, " game_over"}, int'(game_over), go);
        chk({tag, " new_high"}, int'(new_high), nh);
    endtask

    // Drive one cycle of events, then sample just after the edge.
    task automatic step(input logic st, input logic bh, input int pts,
                        input logic ph, input logic bl);
        start = st; brick_hit = bh; brick_pts = 3'(pts);
        paddle_hit = ph; ball_lost = bl;
        @(posedge clk);
        #1;
        start = 1'b0; brick_hit = 1'b0; brick_pts = 3'd0;
        paddle_hit = 1'b0; ball_lost = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Game 1: combo build-up, cap, paddle clear, same-cycle events, record.
        vecs.push_back(mk(0, 1, 7, 1, 1,   0,   0, 0, 0, 0, 0)); // events in IDLE ignored
        vecs.push_back(mk(1, 0, 0, 0, 0,   0,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,   5,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  15,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  30,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  50,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  70,   0, 3, 1, 0, 0)); // capped at x4
        vecs.push_back(mk(0, 0, 0, 1, 0,  70,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  75,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  85,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7, 1, 0, 106,   0, 3, 1, 0, 0)); // x3 then clear
        vecs.push_back(mk(0, 1, 7, 0, 0, 113,   0, 3, 1, 0, 0)); // x1
        vecs.push_back(mk(0, 0, 0, 1, 0, 113,   0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7, 0, 1, 120,   0, 2, 1, 0, 0)); // brick + ball_lost
        vecs.push_back(mk(0, 0, 0, 0, 1, 120,   0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 120,   0, 1, 1, 0, 0)); // zero points
        vecs.push_back(mk(0, 0, 0, 0, 1, 120,   0, 0, 0, 0, 0)); // enter COMMIT
        vecs.push_back(mk(0, 0, 0, 0, 0, 120, 120, 0, 0, 1, 1)); // committed
        vecs.push_back(mk(0, 1, 7, 1, 1, 120, 120, 0, 0, 1, 1)); // GAME_OVER ignores events
        // Game 2: ends at 100, below the record.
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,   5, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  15, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  30, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  50, 120, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  50, 120, 3, 1, 0, 0)); // start while PLAYING
        vecs.push_back(mk(0, 0, 0, 1, 0,  50, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  55, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  65, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  80, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  80, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 1, 0,  85, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0,  90, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5, 0, 0, 100, 120, 3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 100, 120, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 100, 120, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 100, 120, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 100, 120, 0, 0, 1, 0)); // start in COMMIT ignored
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 120, 3, 1, 0, 0)); // new game keeps record

        rst_n = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].st, vecs[i].bh, int'(vecs[i].pts), vecs[i].ph, vecs[i].bl);
            chk_all($sformatf("vec%0d", i), vecs[i].score, vecs[i].high,
                    vecs[i].lv, vecs[i].pl, vecs[i].go, vecs[i].nh);
        end

        // Game 3 reaches 50, then reset drops mid-cycle.
        for (int i = 0; i < 4; i++) step(0, 1, 5, 0, 0);
        chk_all("pre_reset", 50, 120, 3, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_all("start_in_reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk_all("after_release", 0, 0, 0, 0, 0, 0);

        // Game 4: drive to saturation.
        step(1, 0, 0, 0, 0);
        chk_all("g4_start", 0, 0, 3, 1, 0, 0);
        for (int i = 0; i < 358; i++) step(0, 1, 7, 0, 0);
        chk_all("g4_9982", 9982, 0, 3, 1, 0, 0);
        step(0, 1, 2, 1, 0);
        chk_all("g4_9990", 9990, 0, 3, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk_all("g4_combo_rebuilt", 9990, 0, 3, 1, 0, 0);
        step(0, 1, 7, 0, 0);
        chk_all("g4_saturate", 9999, 0, 3, 1, 0, 0);
        step(0, 1, 7, 0, 0);
        chk_all("g4_hold", 9999, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_all("g4_commit_cycle", 9999, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk_all("g4_game_over", 9999, 9999, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Produces the 14-bit current_score and high_score words consumed by the seven-segment score display path; it is the writer side of that score interface.
- Tracks game state, lives, a brick-combo multiplier and saturating score arithmetic from single-cycle game events.
- Commits the high score at game end.
- Sits between the ball/brick collision logic and the display top level, on the same system clock.

Parameters:
- SCORE_W, 14, width of both score outputs.
- SCORE_MAX, 9999, saturation ceiling; the display shows 4 decimal digits.
- START_LIVES, 3, lives loaded on start; must fit in 2 bits.
- MAX_COMBO, 3, combo counter ceiling; multiplier = combo + 1, so maximum x4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new game
- brick_hit  in  1  one-cycle pulse; a brick was destroyed
- brick_pts  in  3  base points of that brick (0-7), valid with brick_hit
- paddle_hit  in  1  one-cycle pulse; ball touched the paddle, which clears the combo
- ball_lost  in  1  one-cycle pulse; ball left the bottom edge
- current_score  out  SCORE_W  running score, binary
- high_score  out  SCORE_W  best committed score, binary
- lives  out  2  remaining lives
- playing  out  1  high in PLAYING
- game_over  out  1  high in GAME_OVER
- new_high  out  1  high from the commit until the next start if the last game set a record

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). All outputs registered.
- Reset values:
  - State IDLE.
  - current_score=0, high_score=0, lives=0, combo=0.
  - playing=0, game_over=0, new_high=0.
- States: IDLE, PLAYING, COMMIT, GAME_OVER.
- IDLE or GAME_OVER + start:
  - Next state PLAYING.
  - current_score<=0, lives<=START_LIVES, combo<=0, new_high<=0.
  - high_score is kept.
- PLAYING, brick_hit:
  - current_score <= min(current_score + brick_pts*(combo+1), SCORE_MAX).
  - combo <= min(combo+1, MAX_COMBO).
  - Visible one cycle after the pulse.
  - The intermediate sum is computed at SCORE_W+1 bits so no wrap-around is possible.
- PLAYING, paddle_hit: combo<=0.
- Same cycle brick_hit and paddle_hit:
  - Points are scored with the pre-clear multiplier.
  - combo ends at 0.
- brick_pts=0 with brick_hit: score unchanged; combo still increments.
- PLAYING, ball_lost: lives<=lives-1 and combo<=0.
  - If lives was 1, next state COMMIT; lives reads 0.
- Same cycle brick_hit and ball_lost: the brick's points are scored, then the life loss applies.
- COMMIT (exactly 1 cycle):
  - If current_score > high_score, then high_score<=current_score and new_high<=1.
  - Equal scores do not set new_high.
  - Next state GAME_OVER.
- GAME_OVER: all event inputs are ignored; only start acts.
- start while PLAYING or COMMIT is ignored.
- Events in IDLE are ignored.
- Output decode:
  - playing=1 only in PLAYING.
  - game_over=1 only in GAME_OVER.
  - Both outputs are registered alongside the state.
- Reset asserted mid-game: everything returns to reset values at once, including high_score.

Decomposition:
- Shared package (score_pkg) holds:
  - the state enum (IDLE, PLAYING, COMMIT, GAME_OVER);
  - SCORE_W, SCORE_MAX, START_LIVES, MAX_COMBO;
  - the brick_pts width constant.
- The display path imports the same SCORE_W and SCORE_MAX.
- One sub-module, score_sat_add. It is combinational and takes score, pts and multiplier, returning the saturated sum.
- The FSM, lives counter and combo counter stay in score_keeper.

Test Plan:
- Reset, then start, then brick_hit with brick_pts=5 four times with no paddle_hit:
  - Scores accumulate 5, 15, 30, 50 (x1, x2, x3, x4).
  - A fifth hit gives 70 (multiplier capped at x4).
- brick_hit with pts=7 and paddle_hit in the same cycle while combo=2:
  - Score increases by 21.
  - The next brick_hit with pts=7 adds 7.
- Preload current_score to 9990 via hits, then brick_hit pts=7 at x4:
  - current_score=9999.
  - Further hits hold 9999.
- Three ball_lost pulses after scoring 120:
  - lives reads 2, 1, 0.
  - One COMMIT cycle follows.
  - high_score=120, new_high=1, game_over=1.
- Second game scoring 100, then game over:
  - high_score stays 120 and new_high=0.
  - start clears current_score but high_score stays 120.
- rst_n low mid-PLAYING with score 50 and high 120:
  - All outputs read 0 immediately (asynchronously).
  - start is ignored until rst_n is released.
